fetch_unit: RTL and testbench
=============================

# fetch_unit

Multicycle instruction fetch unit for the MIPS core. It owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and holds each fetched instruction stable while the control path decodes it. On retirement it takes `pcsrc` and `jump` back from the controller and selects the next PC. It is the supplying end of the controller's `op`/`funct` inputs and the consuming end of its `pcsrc`/`jump` outputs.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 00.

Ports:
- `clk`  in  1  single clock, all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, held until granted.
- `imem_addr`  out  32  word-aligned fetch address, equal to `pc`.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr`, `op`, `funct`, `pc`, `pcplus4` are valid for execution.
- `instr_ready`  in  1  datapath retires the held instruction this cycle.
- `pcsrc`  in  1  branch taken; from controller; sampled only at retirement.
- `jump`  in  1  jump; from controller; sampled only at retirement.
- `pc`  out  32  address of the current instruction.
- `pcplus4`  out  32  `pc + 4`, mod 2^32.
- `fetch_count`  out  32  retired instruction count; wraps.

## Operation
- State machine: RESET, REQ, WAIT, HOLD.
- **RESET**
  - Entered asynchronously whenever `reset` = 0.
  - Outputs and registers while in RESET:
    - `pc` = `RESET_PC`.
    - `instr` = 0.
    - `fetch_count` = 0.
    - `imem_req` = 0.
    - `instr_valid` = 0.
  - Advances to REQ on the first rising edge with `reset` = 1.
- **REQ**
  - `imem_req` = 1, `imem_addr` = `pc`.
  - `imem_gnt` = 1 moves to WAIT.
  - `imem_rvalid` is ignored in REQ. This discards stale responses.
- **WAIT**
  - `imem_req` = 0.
  - On `imem_rvalid` = 1: `instr` <= `imem_rdata`, then go to HOLD.
  - Memory never asserts `rvalid` in the same cycle as `gnt`.
- **HOLD**
  - `instr_valid` = 1.
  - `instr` and `pc` are stable until retirement.
  - On `instr_ready` = 1, retire:
    - `fetch_count` += 1.
    - `pc` <= next PC.
    - Go to REQ.
  - Without `instr_ready`, remain in HOLD indefinitely.
- **Next PC** (priority order):
  - `jump` = 1: `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - else `pcsrc` = 1: `pcplus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - else: `pcplus4`.
- **Arithmetic:** all PC arithmetic is 32-bit and wraps; 0xFFFF_FFFC + 4 = 0.
- **Signal validity:**
  - `op` and `funct` are continuous slices of `instr`.
  - `pcsrc` and `jump` are don't-care outside retirement.
- **Reset mid-operation:** in any state, `reset` low immediately forces the RESET values. An outstanding memory response is then discarded by the REQ rule.

## Timing
- **Minimum cycle count** (zero-wait memory, `instr_ready` tied high): 3 cycles per instruction.
  - Cycle 1, REQ: gnt.
  - Cycle 2, WAIT: rvalid.
  - Cycle 3, HOLD: retire.
- **First request:** `imem_req` rises in the first cycle after reset deassertion.
- **Held outputs:** `instr_valid` rises the cycle after the rvalid capture edge, and falls the cycle after retirement.
- **Wait states:** each cycle of `imem_gnt` delay, `imem_rvalid` delay, or `instr_ready` low adds exactly one cycle.
- **Registered outputs:** `pc`, `instr` and `fetch_count` change only on retirement, capture, or reset.
- **Decoded outputs:** `imem_req` and `instr_valid` are decoded from state only, with no combinational path from inputs.

## Test plan
- **Reset values:** hold `reset` = 0 for 3 cycles, then release.
  - During reset: `imem_req` = 0, `instr_valid` = 0, `pc` = 0, `fetch_count` = 0.
  - Next cycle: `imem_req` = 1, `imem_addr` = 0.
- **Sequential fetch:** zero-wait memory returning add/sub R-types, `instr_ready` = 1.
  - Fetch addresses are 0, 4, 8, one every 3 cycles.
  - `op`/`funct` match the data.
  - `fetch_count` = 3 after the third retirement.
- **Taken branch:** `beq` 0x1000_FFFE at `pc` 0x40, `pcsrc` = 1 at retirement.
  - Next `imem_addr` = 0x3C.
  - Same instruction with `pcsrc` = 0 gives 0x44.
- **Jump:** `j` 0x0800_0010 at `pc` 0x4000_0000, `jump` = 1 and `pcsrc` = 1.
  - Next `imem_addr` = 0x4000_0040; jump wins over branch.
- **Stalls:**
  - gnt delayed 2 cycles, rvalid delayed 3 cycles, `instr_ready` low 4 cycles.
  - Instruction period = 12 cycles.
  - `instr` and `pc` stable throughout HOLD.
- **Reset mid-WAIT and wrap:**
  - Assert `reset` in WAIT, release, then inject a stale rvalid while in REQ: it is ignored and the fetch proceeds at `RESET_PC`.
  - With `RESET_PC` = 0xFFFF_FFFC and a non-branch instruction: next fetch is at 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch unit: owns the PC, fetches one word per
// instruction over a req/gnt/rvalid handshake, holds it for decode, and
// selects the next PC from jump/pcsrc at retirement.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StReset, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_next;
  logic [31:0] br_offset;

  // Next-PC select: jump has priority over a taken branch.
  always_comb begin
    br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump) begin
      pc_next = {pcplus4[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      pc_next = pcplus4 + br_offset;
    end else begin
      pc_next = pcplus4;
    end
  end

  // FSM next state, register updates and state-decoded handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      StReset: state_d = StReq;
      StReq: begin
        // rvalid is deliberately ignored here so stale responses are dropped.
        imem_req = 1'b1;
        if (imem_gnt) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          count_d = count_q + 32'd1;
          pc_d    = pc_next;
          state_d = StReq;
        end
      end
      default: state_d = StReset;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReset;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pcplus4     = pc_q + 32'd4;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances with different reset PCs
// share the memory/controller stimulus; only the selected one leaves reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        gnt = 1'b0, rvalid = 1'b0, ready = 1'b0, pcsrc = 1'b0, jump = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        rst_v [3];

  logic        req_w [3];
  logic        valid_w [3];
  logic [31:0] addr_w [3], instr_w [3], pc_w [3], pc4_w [3], cnt_w [3];
  logic [5:0]  op_w [3], funct_w [3];

  logic        req, valid;
  logic [31:0] addr, instr, pc, pc4, cnt;
  logic [5:0]  op, funct;

  int sel = 0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int prev_start = 0;
  logic [31:0] exp_cnt = 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [31:0] Rpc = (g == 0) ? 32'h0000_0000 :
                                  (g == 1) ? 32'h4000_0000 : 32'hFFFF_FFFC;
    fetch_unit #(.RESET_PC(Rpc)) u_dut (
      .clk        (clk),
      .reset      (rst_v[g]),
      .imem_req   (req_w[g]),
      .imem_addr  (addr_w[g]),
      .imem_gnt   (gnt),
      .imem_rvalid(rvalid),
      .imem_rdata (rdata),
      .instr      (instr_w[g]),
      .op         (op_w[g]),
      .funct      (funct_w[g]),
      .instr_valid(valid_w[g]),
      .instr_ready(ready),
      .pcsrc      (pcsrc),
      .jump       (jump),
      .pc         (pc_w[g]),
      .pcplus4    (pc4_w[g]),
      .fetch_count(cnt_w[g])
    );
  end

  always_comb begin
    req   = req_w[sel];
    valid = valid_w[sel];
    addr  = addr_w[sel];
    instr = instr_w[sel];
    pc    = pc_w[sel];
    pc4   = pc4_w[sel];
    cnt   = cnt_w[sel];
    op    = op_w[sel];
    funct = funct_w[sel];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Put instance idx through a 3-cycle reset (others held in reset).
  task automatic do_reset(input int idx, input logic [31:0] rpc);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    sel = idx;
    exp_cnt = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", {31'h0, req}, 32'h0);
    check_eq("rst_valid", {31'h0, valid}, 32'h0);
    check_eq("rst_pc", pc, rpc);
    check_eq("rst_cnt", cnt, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    rst_v[idx] = 1'b1;
    @(negedge clk);
    check_eq("rel_req", {31'h0, req}, 32'h1);
    check_eq("rel_addr", addr, rpc);
  endtask

  // One complete instruction fetch/hold/retire with the given stall counts.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int gd, input int rd,
                       input int yd, input logic ps, input logic jp);
    for (int i = 0; i < 20 && !req; i++) @(negedge clk);
    check_eq("req", {31'h0, req}, 32'h1);
    check_eq("addr", addr, a);
    prev_start = start_cyc;
    start_cyc = cyc;
    repeat (gd) @(negedge clk);
    if (gd > 0) check_eq("gnt_wait_req", {31'h0, req}, 32'h1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check_eq("wait_req", {31'h0, req}, 32'h0);
    repeat (rd) @(negedge clk);
    rvalid = 1'b1;
    rdata = d;
    @(negedge clk);
    rvalid = 1'b0;
    rdata = 32'hDEAD_BEEF;
    check_eq("valid", {31'h0, valid}, 32'h1);
    check_eq("instr", instr, d);
    check_eq("op", {26'h0, op}, {26'h0, d[31:26]});
    check_eq("funct", {26'h0, funct}, {26'h0, d[5:0]});
    check_eq("pc", pc, a);
    check_eq("pcplus4", pc4, a + 32'd4);
    repeat (yd) @(negedge clk);
    if (yd > 0) begin
      check_eq("hold_instr", instr, d);
      check_eq("hold_pc", pc, a);
      check_eq("hold_valid", {31'h0, valid}, 32'h1);
    end
    ready = 1'b1;
    pcsrc = ps;
    jump = jp;
    @(negedge clk);
    ready = 1'b0;
    pcsrc = 1'b0;
    jump = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    check_eq("retire_cnt", cnt, exp_cnt);
    check_eq("retire_valid", {31'h0, valid}, 32'h0);
  endtask

  localparam logic [31:0] Add = 32'h0022_1820;
  localparam logic [31:0] Sub = 32'h0022_1822;
  localparam logic [31:0] Beq = 32'h1000_FFFE;
  localparam logic [31:0] Jmp = 32'h0800_0010;

  initial begin
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

    do_reset(0, 32'h0);
    fetch(32'h0, Add, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h4, Sub, 0, 0, 0, 1'b0, 1'b0);
    check_eq("period_zero_wait", start_cyc - prev_start, 32'd3);
    fetch(32'h8, Add, 0, 0, 0, 1'b0, 1'b0);
    check_eq("count3", cnt, 32'd3);
    fetch(32'hC, Jmp, 0, 0, 0, 1'b0, 1'b1);
    fetch(32'h40, Beq, 0, 0, 0, 1'b1, 1'b0);
    fetch(32'h3C, Jmp, 0, 0, 0, 1'b0, 1'b1);
    fetch(32'h40, Beq, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h44, Add, 2, 3, 4, 1'b0, 1'b0);
    fetch(32'h48, Sub, 0, 0, 0, 1'b0, 1'b0);
    check_eq("period_stall", start_cyc - prev_start, 32'd12);

    // Reset while in WAIT, then a stale response arriving during REQ.
    for (int i = 0; i < 20 && !req; i++) @(negedge clk);
    check_eq("stale_addr0", addr, 32'h4C);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rst_v[0] = 1'b0;
    #1;
    check_eq("midrst_req", {31'h0, req}, 32'h0);
    check_eq("midrst_pc", pc, 32'h0);
    check_eq("midrst_cnt", cnt, 32'h0);
    exp_cnt = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rvalid = 1'b1;
    rdata = 32'hBADB_AD00;
    @(negedge clk);
    rvalid = 1'b0;
    check_eq("stale_req", {31'h0, req}, 32'h1);
    check_eq("stale_valid", {31'h0, valid}, 32'h0);
    check_eq("stale_instr", instr, 32'h0);
    fetch(32'h0, Add, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h4, Sub, 0, 0, 0, 1'b0, 1'b0);

    // Jump beats branch at a high-region PC.
    do_reset(1, 32'h4000_0000);
    fetch(32'h4000_0000, Jmp, 0, 0, 0, 1'b1, 1'b1);
    fetch(32'h4000_0040, Add, 0, 0, 0, 1'b0, 1'b0);

    // PC wraps from the top of the address space.
    do_reset(2, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, Add, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h0, Sub, 0, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
